// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, encodings and pipeline-state type for the pipeline sequencer.
package pipe_ctrl_pkg;
  localparam int WORD_ADDR_W = 30;
  localparam int CTRL_OP_W   = 2;
  localparam int ISA_EXP_W   = 3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;

  localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP  = 2'd0;
  localparam logic [CTRL_OP_W-1:0] CTRL_OP_WRCR = 2'd1;
  localparam logic [CTRL_OP_W-1:0] CTRL_OP_ERET = 2'd2;

  localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_EXT_INT    = 3'd1;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_UNDEF_INSN = 3'd2;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_OVERFLOW   = 3'd3;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_TRAP       = 3'd5;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_PRV_VIO    = 3'd6;

  typedef enum logic {PIPE_STATE_RUN = 1'b0, PIPE_STATE_EXC = 1'b1} pipe_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [WORD_ADDR_W-1:0] restart_pc(input logic [WORD_ADDR_W-1:0] pc,
                                                        input logic br_flag);
    return br_flag ? pc - 30'd1 : pc;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// MEM-stage status in, per-register stall/flush and redirect out.
// irq exists only when PIPE_CTRL_INT_EN is defined.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic                   if_busy, mem_busy, ld_hazard;
  logic [WORD_ADDR_W-1:0] mem_pc;
  logic                   mem_en_, mem_br_flag;
  logic [CTRL_OP_W-1:0]   mem_ctrl_op;
  logic [ISA_EXP_W-1:0]   mem_exp_code;
`ifdef PIPE_CTRL_INT_EN
  logic                   irq;
`endif
  logic                   if_stall, id_stall, ex_stall, mem_stall;
  logic                   if_flush, id_flush, ex_flush, mem_flush;
  logic [WORD_ADDR_W-1:0] new_pc, epc;
  logic [ISA_EXP_W-1:0]   exp_cause;

  modport slave (
    input  if_busy, mem_busy, ld_hazard, mem_pc, mem_en_, mem_br_flag, mem_ctrl_op, mem_exp_code,
`ifdef PIPE_CTRL_INT_EN
    input  irq,
`endif
    output if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush,
    output new_pc, epc, exp_cause
  );

  modport master (
    output if_busy, mem_busy, ld_hazard, mem_pc, mem_en_, mem_br_flag, mem_ctrl_op, mem_exp_code,
`ifdef PIPE_CTRL_INT_EN
    output irq,
`endif
    input  if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush,
    input  new_pc, epc, exp_cause
  );
endinterface

// File: rtl/pipe_ctrl_epc.sv
// Exception register file: epc, cause and interrupt enable, with capture and ERET update.
module pipe_ctrl_epc
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_i,
  input  logic [WORD_ADDR_W-1:0] cap_pc_i,
  input  logic [ISA_EXP_W-1:0]   cap_cause_i,
  input  logic                   eret_i,
  output logic [WORD_ADDR_W-1:0] epc_o,
  output logic [ISA_EXP_W-1:0]   cause_o,
  output logic                   ie_o
);
  logic [WORD_ADDR_W-1:0] epc_q, epc_d;
  logic [ISA_EXP_W-1:0]   cause_q, cause_d;
  logic                   ie_q, ie_d;

  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    ie_d    = ie_q;
    if (cap_i) begin
      epc_d   = cap_pc_i;
      cause_d = cap_cause_i;
      ie_d    = DISABLE;
    end else if (eret_i) begin
      ie_d    = ENABLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q   <= '0;
      cause_q <= ISA_EXP_NO_EXP;
      ie_q    <= DISABLE;
    end else begin
      epc_q   <= epc_d;
      cause_q <= cause_d;
      ie_q    <= ie_d;
    end
  end

  assign epc_o   = epc_q;
  assign cause_o = cause_q;
  assign ie_o    = ie_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush priority decoder and precise-exception state machine.
// Define PIPE_CTRL_INT_EN to add the level-sensitive external interrupt path.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [WORD_ADDR_W-1:0] EXC_VECTOR = '0
) (
  input  logic      clk,
  input  logic      reset,
  pipe_ctrl_if.slave bus
);
  pipe_state_e            state_q, state_d;
  logic [WORD_ADDR_W-1:0] tgt_q, tgt_d;
  logic [3:0]             stall, flush;
  logic [WORD_ADDR_W-1:0] new_pc;
  logic                   valid, exc, eret, irq_take, ie;
  logic                   cap, eret_set;
  logic [ISA_EXP_W-1:0]   cap_cause;
  logic [WORD_ADDR_W-1:0] epc;

  assign valid = (bus.mem_en_ == ENABLE_);
  assign exc   = valid && (bus.mem_exp_code != ISA_EXP_NO_EXP);
  assign eret  = valid && (bus.mem_ctrl_op == CTRL_OP_ERET);

`ifdef PIPE_CTRL_INT_EN
  assign irq_take = bus.irq && ie && valid && !exc;
`else
  logic ie_unused;
  assign irq_take  = 1'b0;
  assign ie_unused = ie;
`endif

  always_comb begin
    stall     = 4'b0000;
    flush     = 4'b0000;
    new_pc    = '0;
    state_d   = state_q;
    tgt_d     = tgt_q;
    cap       = 1'b0;
    cap_cause = exc ? bus.mem_exp_code : ISA_EXP_EXT_INT;
    eret_set  = 1'b0;
    if (!reset) begin
      if (bus.if_busy || bus.mem_busy) begin
        stall = 4'b1111;
      end else if (state_q == PIPE_STATE_EXC) begin
        // Wrong-path leftovers drain here; fetch keeps the redirect target.
        flush   = 4'b1111;
        new_pc  = tgt_q;
        state_d = PIPE_STATE_RUN;
      end else if (exc || irq_take) begin
        flush   = 4'b1111;
        new_pc  = EXC_VECTOR;
        tgt_d   = EXC_VECTOR;
        cap     = 1'b1;
        state_d = PIPE_STATE_EXC;
      end else if (eret) begin
        flush    = 4'b1111;
        new_pc   = epc;
        tgt_d    = epc;
        eret_set = 1'b1;
        state_d  = PIPE_STATE_EXC;
      end else if (bus.ld_hazard) begin
        stall = 4'b1100;
        flush = 4'b0010;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PIPE_STATE_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  pipe_ctrl_epc u_epc (
    .clk        (clk),
    .reset      (reset),
    .cap_i      (cap),
    .cap_pc_i   (restart_pc(bus.mem_pc, bus.mem_br_flag)),
    .cap_cause_i(cap_cause),
    .eret_i     (eret_set),
    .epc_o      (epc),
    .cause_o    (bus.exp_cause),
    .ie_o       (ie)
  );

  assign {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall} = stall;
  assign {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush} = flush;
  assign bus.new_pc = new_pc;
  assign bus.epc    = epc;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed check of pipe_ctrl against a priority-rule model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  localparam logic [WORD_ADDR_W-1:0] VEC = 30'h200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus();
  pipe_ctrl #(.EXC_VECTOR(VEC)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Model state: in the drain cycle, last redirect, captured epc/cause/ie.
  bit                     m_exc = 0;
  bit                     m_ie  = 0;
  logic [WORD_ADDR_W-1:0] m_epc = '0, m_tgt = '0;
  logic [ISA_EXP_W-1:0]   m_cause = '0;

  int                     row;
  logic                   e_valid, e_exc, e_eret, e_irq;
  logic [3:0]             e_stall, e_flush;
  logic [WORD_ADDR_W-1:0] e_npc;

  always_comb begin
    e_valid = (bus.mem_en_ == 1'b0);
    e_exc   = e_valid && (bus.mem_exp_code != 3'd0);
    e_eret  = e_valid && (bus.mem_ctrl_op == 2'd2);
    e_irq   = 1'b0;
`ifdef PIPE_CTRL_INT_EN
    e_irq   = bus.irq && m_ie && e_valid && !e_exc;
`endif
    if (reset)                          row = 0;
    else if (bus.if_busy || bus.mem_busy) row = 1;
    else if (m_exc)                     row = 5;
    else if (e_exc || e_irq)            row = 2;
    else if (e_eret)                    row = 3;
    else if (bus.ld_hazard)             row = 4;
    else                                row = 0;
    e_stall = 4'b0000; e_flush = 4'b0000; e_npc = '0;
    case (row)
      1: e_stall = 4'b1111;
      2: begin e_flush = 4'b1111; e_npc = VEC; end
      3: begin e_flush = 4'b1111; e_npc = m_epc; end
      4: begin e_stall = 4'b1100; e_flush = 4'b0010; end
      5: begin e_flush = 4'b1111; e_npc = m_tgt; end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      m_exc <= 0; m_ie <= 0; m_epc <= '0; m_tgt <= '0; m_cause <= 3'd0;
    end else begin
      case (row)
        2: begin
          m_exc   <= 1;
          m_epc   <= bus.mem_br_flag ? bus.mem_pc - 30'd1 : bus.mem_pc;
          m_cause <= e_exc ? bus.mem_exp_code : 3'd1;
          m_ie    <= 0;
          m_tgt   <= VEC;
        end
        3: begin m_exc <= 1; m_ie <= 1; m_tgt <= m_epc; end
        5: m_exc <= 0;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("stall", {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall}, e_stall);
      chk("flush", {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}, e_flush);
      if (e_flush[3]) chk("new_pc", bus.new_pc, e_npc);
      chk("epc", bus.epc, m_epc);
      chk("exp_cause", bus.exp_cause, m_cause);
    end
  end

  task automatic drive(input bit ib, input bit mb, input bit hz, input bit en_, input bit br,
                       input logic [1:0] op, input logic [2:0] code, input logic [29:0] pc);
    bus.if_busy = ib; bus.mem_busy = mb; bus.ld_hazard = hz; bus.mem_en_ = en_;
    bus.mem_br_flag = br; bus.mem_ctrl_op = op; bus.mem_exp_code = code; bus.mem_pc = pc;
`ifdef PIPE_CTRL_INT_EN
    bus.irq = 1'b0;
`endif
  endtask

  task automatic idle(); drive(0, 0, 0, 1, 0, 2'd0, 3'd0, 30'h0); endtask
  task automatic step(); @(posedge clk); #1; endtask
  task automatic at_neg(); @(negedge clk); endtask

  function automatic logic [3:0] fl(); return {bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}; endfunction
  function automatic logic [3:0] st(); return {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall}; endfunction

  initial begin
    idle();
    step(); step();
    reset = 1'b0;
    at_neg();
    chk("rst_stall", st(), 4'h0); chk("rst_flush", fl(), 4'h0);
    chk("rst_epc", bus.epc, 0); chk("rst_cause", bus.exp_cause, 0);

    // Misaligned access, not in a delay slot, then in a delay slot.
    for (int b = 0; b < 2; b++) begin
      step(); drive(0, 0, 0, 0, b[0], 2'd0, 3'd4, 30'h40);
      at_neg(); chk("exc_flush", fl(), 4'hF); chk("exc_vec", bus.new_pc, VEC);
      step(); idle();
      at_neg(); chk("exc_epc", bus.epc, (b == 0) ? 30'h40 : 30'h3F);
      chk("exc_cause", bus.exp_cause, 3'd4); chk("drain_flush", fl(), 4'hF);
      step();
      at_neg(); chk("run_flush", fl(), 4'h0);
    end

    // Back-to-back exceptions: the second is a wrong-path leftover.
    step(); drive(0, 0, 0, 0, 0, 2'd0, 3'd3, 30'h50);
    step(); drive(0, 0, 0, 0, 0, 2'd0, 3'd5, 30'h60);
    at_neg(); chk("dbl_flush", fl(), 4'hF);
    step(); idle();
    at_neg(); chk("dbl_epc", bus.epc, 30'h50); chk("dbl_cause", bus.exp_cause, 3'd3);
    chk("dbl_run", fl(), 4'h0);

    // Busy holds a pending exception.
    step(); drive(0, 1, 0, 0, 0, 2'd0, 3'd4, 30'h70);
    for (int i = 0; i < 3; i++) begin
      at_neg(); chk("busy_stall", st(), 4'hF); chk("busy_flush", fl(), 4'h0);
      step();
    end
    bus.mem_busy = 1'b0;
    at_neg(); chk("busy_epc", bus.epc, 30'h50);
    chk("unbusy_flush", fl(), 4'hF); chk("unbusy_vec", bus.new_pc, VEC);
    step(); idle();
    at_neg(); chk("unbusy_epc", bus.epc, 30'h70);
    step();

    // Reset held two cycles mid-EXC.
    drive(0, 0, 0, 0, 0, 2'd0, 3'd2, 30'h99);
    step(); idle(); reset = 1'b1;
    step(); step(); reset = 1'b0;
    at_neg(); chk("mid_rst_flush", fl(), 4'h0); chk("mid_rst_stall", st(), 4'h0);
    chk("mid_rst_epc", bus.epc, 0); chk("mid_rst_cause", bus.exp_cause, 0);

    // ERET returns to a captured epc of 0x123.
    step(); drive(0, 0, 0, 0, 0, 2'd0, 3'd4, 30'h123);
    step(); idle(); step();
    drive(0, 0, 0, 0, 0, 2'd2, 3'd0, 30'h5);
    at_neg(); chk("eret_flush", fl(), 4'hF); chk("eret_pc", bus.new_pc, 30'h123);
    step(); idle();
    at_neg(); chk("eret_drain", fl(), 4'hF);
    step();

`ifdef PIPE_CTRL_INT_EN
    // ie is enabled after the ERET above.
    drive(0, 0, 0, 0, 0, 2'd0, 3'd0, 30'h10); bus.irq = 1'b1;
    at_neg(); chk("irq_flush", fl(), 4'hF); chk("irq_vec", bus.new_pc, VEC);
    step(); idle();
    at_neg(); chk("irq_epc", bus.epc, 30'h10); chk("irq_cause", bus.exp_cause, 3'd1);
    step();
    drive(0, 0, 0, 0, 0, 2'd0, 3'd0, 30'h10); bus.irq = 1'b1;
    at_neg(); chk("irq_ie0", fl(), 4'h0);
    step(); idle();
`endif

    // Load-use bubble, then an invalid instruction carrying stale exc/ERET.
    drive(0, 0, 1, 1, 0, 2'd0, 3'd0, 30'h0);
    at_neg(); chk("haz_stall", st(), 4'b1100); chk("haz_flush", fl(), 4'b0010);
    step(); drive(0, 0, 0, 1, 0, 2'd2, 3'd4, 30'h77);
    at_neg(); chk("inval_flush", fl(), 4'h0); chk("inval_stall", st(), 4'h0);
    step();

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 2'd2 : 2'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 6)) : 3'd0,
            30'($urandom));
`ifdef PIPE_CTRL_INT_EN
      bus.irq = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    reset = 1'b0; idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
